jk_counter_reg: RTL and testbench

Parametrised WIDTH-bit register built from JK flip-flop cells, extending the single-bit JK flip-flop into a multi-mode sequential block. It supports per-bit JK operation, a modulo up/down counter, a serial shift register, and parallel load. It sits in the lab's sequential-logic library as the general-purpose register/counter used by later counter and sequencer exercises.

---
 rtl/jk_pkg.sv | 47 ++++
 rtl/jkff_cell.sv | 35 +++
 rtl/jk_counter_reg.sv | 104 ++++++++++
 tb/tb_jk_counter_reg.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// jk_pkg: shared definitions for the JK-cell register/counter.
//
// Contents:
//   MODE_* constants  operating mode encoding of the 2-bit mode input
//   bit_act_e         per-bit next-state intent, encoded so that
//                     bit[1] is the cell J input and bit[0] is the cell K input
//   act_from_target() intent that moves a bit from its current value to a target
//   act_from_jk()     intent given raw J/K inputs (JK mode)
package jk_pkg;

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_COUNT = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  typedef enum logic [1:0] {
    ACT_HOLD   = 2'b00,
    ACT_CLEAR  = 2'b01,
    ACT_SET    = 2'b10,
    ACT_TOGGLE = 2'b11
  } bit_act_e;

  // Counter and shift modes know the desired next value; express the change
  // as set/clear so a bit that already matches is simply held.
  function automatic bit_act_e act_from_target(input logic cur, input logic tgt);
    bit_act_e act;
    act = ACT_HOLD;
    if (tgt && !cur) begin
      act = ACT_SET;
    end else if (!tgt && cur) begin
      act = ACT_CLEAR;
    end
    return act;
  endfunction

  function automatic bit_act_e act_from_jk(input logic jv, input logic kv);
    bit_act_e act;
    case ({jv, kv})
      2'b01:   act = ACT_CLEAR;
      2'b10:   act = ACT_SET;
      2'b11:   act = ACT_TOGGLE;
      default: act = ACT_HOLD;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/jkff_cell.sv
// jkff_cell: single-bit JK flip-flop with synchronous parallel load.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset, clears q
//   j, k    in   JK controls: 00 hold, 01 clear, 10 set, 11 toggle
//   ld      in   synchronous load, overrides j/k
//   ld_val  in   value captured when ld=1
//   q       out  flip-flop state
module jkff_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  input  logic ld,
  input  logic ld_val,
  output logic q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else if (ld) begin
      q <= ld_val;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_counter_reg.sv
// jk_counter_reg: WIDTH-bit register built from JK flip-flop cells.
// Modes: per-bit JK, modulo up/down counter, serial shift, hold.
// Parallel load has priority over everything except reset and ignores en.
//
// Parameters:
//   WIDTH  register width, 2..16
//   counter modulus parameter, 2..2**WIDTH
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset, q cleared immediately
//   en     in   enable for mode operations (not for load)
//   load   in   synchronous parallel load of d
//   d      in   parallel load data
//   mode   in   00 JK, 01 COUNT, 10 SHIFT, 11 HOLD
//   dir    in   COUNT direction, 1 up / 0 down
//   j      in   per-bit J; j[0] is the serial input in SHIFT mode
//   k      in   per-bit K (JK mode only)
//   q      out  register state
//   qn     out  ~q
//   tc     out  terminal count, combinational, high in the cycle before a wrap
module jk_counter_reg
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc
);

  // Counter terminal value at WIDTH bits; full modulus yields all ones.
  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  bit_act_e         act [WIDTH];

  // Up-count wraps at or above TOP_VAL so an out-of-range load recovers in
  // one edge; down-count only special-cases zero.
  always_comb begin
    cnt_next = q;
    if (dir) begin
      cnt_next = (q >= TOP_VAL) ? '0 : q + WIDTH'(1);
    end else begin
      cnt_next = (q == '0) ? TOP_VAL : q - WIDTH'(1);
    end
  end

  assign shift_next = {q[WIDTH-2:0], j[0]};

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      act[i] = ACT_HOLD;
      if (en) begin
        case (mode)
          MODE_JK:    act[i] = act_from_jk(j[i], k[i]);
          MODE_COUNT: act[i] = act_from_target(q[i], cnt_next[i]);
          MODE_SHIFT: act[i] = act_from_target(q[i], shift_next[i]);
          default:    act[i] = ACT_HOLD;
        endcase
      end
    end
  end

  // Intent encoding doubles as the cell's {j, k} pair.
  always_comb begin
    cell_j = '0;
    cell_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cell_j[i] = act[i][1];
      cell_k[i] = act[i][0];
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jkff_cell u_cell (
      .clk    (clk),
      .reset  (reset),
      .j      (cell_j[gi]),
      .k      (cell_k[gi]),
      .ld     (load),
      .ld_val (d[gi]),
      .q      (q[gi])
    );
  end

  assign qn = ~q;

  assign tc = en & (mode == MODE_COUNT) &
              ((dir & (q == TOP_VAL)) | (~dir & (q == '0)));

endmodule

// File: tb/tb_jk_counter_reg.sv
module tb_jk_counter_reg;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] d = '0;
  logic [1:0]   mode = 2'b11;
  logic         dir = 1'b1;
  logic [W-1:0] j = '0;
  logic [W-1:0] k = '0;
  logic [W-1:0] q;
  logic [W-1:0] qn;
  logic         tc;

  int errors = 0;
  int checks = 0;
  int m_q = 0;

  jk_counter_reg #(.WIDTH(W), .MOD(M)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .d(d), .mode(mode),
    .dir(dir), .j(j), .k(k), .q(q), .qn(qn), .tc(tc)
  );

  always #5 clk = ~clk;

  // Reference model: register value as a plain integer 0..15.
  function automatic int model_next(int cur);
    int nx;
    if (load) return int'(d);
    if (!en) return cur;
    case (mode)
      2'b00: begin
        nx = 0;
        for (int b = 0; b < W; b++) begin
          int bit_v;
          bit_v = (cur >> b) & 1;
          if (j[b] && k[b]) bit_v = 1 - bit_v;
          else if (j[b]) bit_v = 1;
          else if (k[b]) bit_v = 0;
          nx += bit_v << b;
        end
        return nx;
      end
      2'b01: begin
        if (dir) return (cur >= M - 1) ? 0 : cur + 1;
        else     return (cur == 0) ? M - 1 : cur - 1;
      end
      2'b10: return ((cur * 2) + int'(j[0])) % 16;
      default: return cur;
    endcase
  endfunction

  function automatic logic model_tc();
    if (!en || mode != 2'b01) return 1'b0;
    return dir ? (m_q == M - 1) : (m_q == 0);
  endfunction

  task automatic drive(input logic ld, input int dv, input logic e,
                       input logic [1:0] md, input logic dr,
                       input logic [W-1:0] jv, input logic [W-1:0] kv);
    load = ld; d = W'(dv); en = e; mode = md; dir = dr; j = jv; k = kv;
  endtask

  task automatic tick();
    int nx;
    nx = model_next(m_q);
    @(posedge clk);
    #1;
    m_q = nx;
  endtask

  task automatic test_reset();
    checks++;
    if (q !== 4'h0 || qn !== 4'hF) begin
      errors++; $display("FAIL reset_state q=%h qn=%h want q=0 qn=F", q, qn);
    end
    @(negedge clk);
    reset = 1'b1;
    // get to q=9 then assert reset between edges
    drive(1'b1, 9, 1'b1, 2'b01, 1'b1, '0, '0);
    tick();
    checks++;
    if (q !== 4'h9) begin
      errors++; $display("FAIL reset_preload q=%h want 9", q);
    end
    drive(1'b0, 0, 1'b1, 2'b01, 1'b0, '0, '0);
    #2;
    reset = 1'b0;
    m_q = 0;
    #1;
    checks++;
    if (q !== 4'h0 || qn !== 4'hF) begin
      errors++; $display("FAIL reset_async q=%h qn=%h want q=0 qn=F", q, qn);
    end
    checks++;
    if (tc !== 1'b1) begin
      errors++; $display("FAIL reset_tc tc=%b want 1", tc);
    end
    @(posedge clk);
    #1;
    checks++;
    if (q !== 4'h0) begin
      errors++; $display("FAIL reset_held_through_edge q=%h want 0", q);
    end
    #2;
    reset = 1'b1;
    dir = 1'b1;
    tick();
    checks++;
    if (q !== 4'h1 || q !== W'(m_q)) begin
      errors++; $display("FAIL reset_resume q=%h want 1", q);
    end
  endtask

  task automatic test_jk();
    drive(1'b1, 5, 1'b0, 2'b00, 1'b0, '0, '0);
    tick();
    drive(1'b0, 0, 1'b1, 2'b00, 1'b0, 4'b0011, 4'b0110);
    tick();
    checks++;
    if (q !== 4'b0011 || q !== W'(m_q) || qn !== 4'b1100) begin
      errors++; $display("FAIL jk_mode q=%b qn=%b want q=0011 qn=1100", q, qn);
    end
    drive(1'b0, 0, 1'b1, 2'b00, 1'b0, 4'b1111, 4'b1111);
    tick();
    checks++;
    if (q !== 4'b1100) begin
      errors++; $display("FAIL jk_toggle_all q=%b want 1100", q);
    end
  endtask

  task automatic test_count_up();
    drive(1'b1, 0, 1'b1, 2'b01, 1'b1, '0, '0);
    tick();
    drive(1'b0, 0, 1'b1, 2'b01, 1'b1, '0, '0);
    for (int s = 0; s < 12; s++) begin
      #1;
      checks++;
      if (tc !== model_tc() || tc !== (q == 4'd9)) begin
        errors++; $display("FAIL count_up_tc step=%0d q=%h tc=%b want %b", s, q, tc, model_tc());
      end
      tick();
      checks++;
      if (q !== W'(m_q) || q !== W'((s + 1) % M)) begin
        errors++; $display("FAIL count_up step=%0d q=%h want %h", s, q, W'(m_q));
      end
    end
  endtask

  task automatic test_count_down();
    drive(1'b1, 0, 1'b1, 2'b01, 1'b0, '0, '0);
    tick();
    drive(1'b0, 0, 1'b1, 2'b01, 1'b0, '0, '0);
    #1;
    checks++;
    if (tc !== 1'b1) begin
      errors++; $display("FAIL count_down_tc tc=%b want 1", tc);
    end
    tick();
    checks++;
    if (q !== 4'd9 || q !== W'(m_q)) begin
      errors++; $display("FAIL count_down_wrap q=%h want 9", q);
    end
    tick();
    checks++;
    if (q !== 4'd8) begin
      errors++; $display("FAIL count_down_step q=%h want 8", q);
    end
    drive(1'b1, 15, 1'b1, 2'b01, 1'b1, '0, '0);
    tick();
    drive(1'b0, 0, 1'b1, 2'b01, 1'b1, '0, '0);
    tick();
    checks++;
    if (q !== 4'd0) begin
      errors++; $display("FAIL count_oor_recover q=%h want 0", q);
    end
    drive(1'b1, 15, 1'b1, 2'b01, 1'b0, '0, '0);
    tick();
    drive(1'b0, 0, 1'b1, 2'b01, 1'b0, '0, '0);
    tick();
    checks++;
    if (q !== 4'd14) begin
      errors++; $display("FAIL count_down_oor q=%h want e", q);
    end
  endtask

  task automatic test_shift();
    logic [W-1:0] exp_seq [4];
    logic         ser [4];
    exp_seq = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
    ser = '{1'b1, 1'b0, 1'b1, 1'b1};
    drive(1'b1, 8, 1'b0, 2'b10, 1'b0, '0, '0);
    tick();
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 0, 1'b1, 2'b10, 1'b0, {3'b101, ser[s]}, 4'b1111);
      tick();
      checks++;
      if (q !== exp_seq[s] || q !== W'(m_q)) begin
        errors++; $display("FAIL shift step=%0d q=%b want %b", s, q, exp_seq[s]);
      end
    end
  endtask

  task automatic test_enable_priority();
    logic [W-1:0] held;
    drive(1'b1, 4, 1'b1, 2'b01, 1'b1, '0, '0);
    tick();
    held = q;
    drive(1'b0, 0, 1'b0, 2'b01, 1'b1, '0, '0);
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++;
      if (tc !== 1'b0) begin
        errors++; $display("FAIL en_low_tc step=%0d tc=%b want 0", s, tc);
      end
      tick();
      checks++;
      if (q !== 4'd4 || q !== held) begin
        errors++; $display("FAIL en_low_hold step=%0d q=%h want 4", s, q);
      end
    end
    drive(1'b1, 6, 1'b0, 2'b01, 1'b1, '0, '0);
    tick();
    checks++;
    if (q !== 4'd6) begin
      errors++; $display("FAIL load_en_low q=%h want 6", q);
    end
    drive(1'b1, 9, 1'b1, 2'b01, 1'b1, '0, '0);
    tick();
    drive(1'b1, 3, 1'b1, 2'b01, 1'b1, '0, '0);
    #1;
    checks++;
    if (tc !== 1'b1) begin
      errors++; $display("FAIL tc_before_load tc=%b want 1", tc);
    end
    tick();
    checks++;
    if (q !== 4'd3) begin
      errors++; $display("FAIL load_beats_wrap q=%h want 3", q);
    end
    drive(1'b0, 0, 1'b1, 2'b11, 1'b1, 4'hF, 4'hF);
    tick();
    checks++;
    if (q !== 4'd3) begin
      errors++; $display("FAIL hold_mode q=%h want 3", q);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 400; s++) begin
      drive(($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
      #1;
      checks++;
      if (tc !== model_tc()) begin
        errors++; $display("FAIL rand_tc step=%0d q=%h tc=%b want %b", s, q, tc, model_tc());
      end
      tick();
      checks++;
      if (q !== W'(m_q) || qn !== ~W'(m_q)) begin
        errors++; $display("FAIL rand_q step=%0d q=%h qn=%h want %h", s, q, qn, W'(m_q));
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_jk();
    test_count_up();
    test_count_down();
    test_shift();
    test_enable_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
